// File: rtl/e203_exu_bjp_rslv.sv
// Branch/jump resolve stage: decides front-end redirects for branch-class commits,
// holds the registered flush request until the IFU accepts it, and counts mispredicts.
module e203_exu_bjp_rslv #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,

  input  logic             cmt_i_valid,
  output logic             cmt_i_ready,
  input  logic [PC_W-1:0]  cmt_i_pc,
  input  logic [PC_W-1:0]  cmt_i_imm,
  input  logic             cmt_i_rvc,
  input  logic             cmt_i_bjp,
  input  logic             cmt_i_prdt,
  input  logic             cmt_i_rslv,
  input  logic             cmt_i_mret,
  input  logic             cmt_i_dret,
  input  logic             cmt_i_fencei,

  input  logic [PC_W-1:0]  csr_mepc_r,
  input  logic [PC_W-1:0]  csr_dpc_r,

  output logic             flush_o_valid,
  input  logic             flush_o_ready,
  output logic [PC_W-1:0]  flush_o_pc,
  output logic [1:0]       flush_o_cause,

  output logic             cmt_o_done,
  output logic [CNT_W-1:0] mispred_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [1:0] CAUSE_MISPRED = 2'd0;
  localparam logic [1:0] CAUSE_FENCEI  = 2'd1;
  localparam logic [1:0] CAUSE_MRET    = 2'd2;
  localparam logic [1:0] CAUSE_DRET    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [1:0]       cause_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  logic             accept_s;
  logic             need_flush_s;
  logic [1:0]       cause_s;
  logic [PC_W-1:0]  nxt_s;
  logic [PC_W-1:0]  tgt_s;
  logic [PC_W-1:0]  redir_s;

  // Handshake-facing outputs come from the state register only, never from inputs.
  assign cmt_i_ready   = (state_q == ST_IDLE);
  assign flush_o_valid = (state_q == ST_FLUSH);
  assign flush_o_pc    = pc_q;
  assign flush_o_cause = cause_q;
  assign cmt_o_done    = done_q;
  assign mispred_cnt   = cnt_q;

  assign accept_s = cmt_i_valid & cmt_i_ready;
  assign nxt_s    = cmt_i_pc + (cmt_i_rvc ? PC_W'(2) : PC_W'(4));
  assign tgt_s    = cmt_i_pc + cmt_i_imm;

  // Fixed-priority redirect decode: dret > mret > fence.i > mispredict.
  always_comb begin
    need_flush_s = 1'b0;
    cause_s      = CAUSE_MISPRED;
    redir_s      = nxt_s;
    if (cmt_i_dret) begin
      need_flush_s = 1'b1;
      cause_s      = CAUSE_DRET;
      redir_s      = csr_dpc_r;
    end else if (cmt_i_mret) begin
      need_flush_s = 1'b1;
      cause_s      = CAUSE_MRET;
      redir_s      = csr_mepc_r;
    end else if (cmt_i_fencei) begin
      need_flush_s = 1'b1;
      cause_s      = CAUSE_FENCEI;
      redir_s      = nxt_s;
    end else if (cmt_i_bjp && (cmt_i_prdt != cmt_i_rslv)) begin
      need_flush_s = 1'b1;
      cause_s      = CAUSE_MISPRED;
      redir_s      = cmt_i_rslv ? tgt_s : nxt_s;
    end else begin
      need_flush_s = 1'b0;
      cause_s      = CAUSE_MISPRED;
      redir_s      = nxt_s;
    end
  end

  // Resolve FSM with registered redirect, retire pulse and saturating mispredict count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= {PC_W{1'b0}};
      cause_q <= 2'd0;
      done_q  <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            if (need_flush_s) begin
              state_q <= ST_FLUSH;
              pc_q    <= redir_s;
              cause_q <= cause_s;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_o_ready) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            if ((cause_q == CAUSE_MISPRED) && (cnt_q != CNT_MAX)) begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_e203_exu_bjp_rslv.sv
// Bench for e203_exu_bjp_rslv: directed vector table, hand-written handshake/reset
// sequences, and random records checked against a reference model.
module tb_e203_exu_bjp_rslv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cmt_i_valid;
  logic [31:0] cmt_i_pc, cmt_i_imm;
  logic        cmt_i_rvc, cmt_i_bjp, cmt_i_prdt, cmt_i_rslv;
  logic        cmt_i_mret, cmt_i_dret, cmt_i_fencei;
  logic [31:0] csr_mepc_r, csr_dpc_r;
  logic        flush_o_ready;

  logic        cmt_i_ready, flush_o_valid, cmt_o_done;
  logic [31:0] flush_o_pc, mispred_cnt;
  logic [1:0]  flush_o_cause;

  logic        ready2, fvalid2, done2;
  logic [31:0] fpc2;
  logic [1:0]  fcause2, cnt2;

  e203_exu_bjp_rslv #(.PC_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(cmt_i_ready),
    .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm), .cmt_i_rvc(cmt_i_rvc),
    .cmt_i_bjp(cmt_i_bjp), .cmt_i_prdt(cmt_i_prdt), .cmt_i_rslv(cmt_i_rslv),
    .cmt_i_mret(cmt_i_mret), .cmt_i_dret(cmt_i_dret), .cmt_i_fencei(cmt_i_fencei),
    .csr_mepc_r(csr_mepc_r), .csr_dpc_r(csr_dpc_r),
    .flush_o_valid(flush_o_valid), .flush_o_ready(flush_o_ready),
    .flush_o_pc(flush_o_pc), .flush_o_cause(flush_o_cause),
    .cmt_o_done(cmt_o_done), .mispred_cnt(mispred_cnt)
  );

  e203_exu_bjp_rslv #(.PC_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .cmt_i_valid(cmt_i_valid), .cmt_i_ready(ready2),
    .cmt_i_pc(cmt_i_pc), .cmt_i_imm(cmt_i_imm), .cmt_i_rvc(cmt_i_rvc),
    .cmt_i_bjp(cmt_i_bjp), .cmt_i_prdt(cmt_i_prdt), .cmt_i_rslv(cmt_i_rslv),
    .cmt_i_mret(cmt_i_mret), .cmt_i_dret(cmt_i_dret), .cmt_i_fencei(cmt_i_fencei),
    .csr_mepc_r(csr_mepc_r), .csr_dpc_r(csr_dpc_r),
    .flush_o_valid(fvalid2), .flush_o_ready(flush_o_ready),
    .flush_o_pc(fpc2), .flush_o_cause(fcause2),
    .cmt_o_done(done2), .mispred_cnt(cnt2)
  );

  typedef struct {
    logic [31:0] pc, imm, mepc, dpc;
    logic        rvc, bjp, prdt, rslv, mret, dret, fencei;
  } rec_t;

  typedef struct {
    rec_t        r;
    bit          ef;
    logic [31:0] epc;
    logic [1:0]  ec;
    int          delay;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  int model_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [31:0] pc, input logic [31:0] imm, input bit rvc,
                              input bit bjp, input bit prdt, input bit rslv, input bit mret,
                              input bit dret, input bit fencei);
    rec_t r;
    r.pc = pc; r.imm = imm; r.rvc = rvc; r.bjp = bjp; r.prdt = prdt; r.rslv = rslv;
    r.mret = mret; r.dret = dret; r.fencei = fencei;
    r.mepc = 32'h0000_6000; r.dpc = 32'h0000_5000;
    return r;
  endfunction

  // Reference model: redirect decision from the architectural rules.
  function automatic void model(input rec_t r, output bit f, output logic [31:0] pc,
                                output logic [1:0] c);
    longint unsigned fall, taken;
    fall  = (longint'(r.pc) + (r.rvc ? 2 : 4)) % 64'h1_0000_0000;
    taken = (longint'(r.pc) + longint'(r.imm)) % 64'h1_0000_0000;
    f = 1'b1; c = 2'd0; pc = fall[31:0];
    if (r.dret)        begin c = 2'd3; pc = r.dpc; end
    else if (r.mret)   begin c = 2'd2; pc = r.mepc; end
    else if (r.fencei) begin c = 2'd1; pc = fall[31:0]; end
    else if (r.bjp && r.prdt != r.rslv) pc = r.rslv ? taken[31:0] : fall[31:0];
    else f = 1'b0;
  endfunction

  task automatic drive(input rec_t r);
    cmt_i_pc = r.pc; cmt_i_imm = r.imm; cmt_i_rvc = r.rvc; cmt_i_bjp = r.bjp;
    cmt_i_prdt = r.prdt; cmt_i_rslv = r.rslv; cmt_i_mret = r.mret;
    cmt_i_dret = r.dret; cmt_i_fencei = r.fencei;
    csr_mepc_r = r.mepc; csr_dpc_r = r.dpc;
  endtask

  task automatic check_cnt(input string name);
    check({name, "_cnt"}, mispred_cnt, model_cnt);
    check({name, "_cnt2"}, 32'(cnt2), (model_cnt > 3) ? 32'd3 : model_cnt);
  endtask

  // One record from acceptance through retirement; flush held for 'delay' cycles.
  task automatic run_rec(input string name, input rec_t r, input bit ef, input logic [31:0] epc,
                         input logic [1:0] ec, input int delay, input bit idle_rdy);
    @(negedge clk);
    drive(r);
    cmt_i_valid = 1'b1;
    flush_o_ready = idle_rdy;
    check({name, "_ready_idle"}, 32'(cmt_i_ready), 32'd1);
    check({name, "_done_low"}, 32'(cmt_o_done), 32'd0);
    @(posedge clk); #1;
    cmt_i_valid = 1'b0;
    flush_o_ready = (delay == 0);
    csr_mepc_r = $urandom;
    csr_dpc_r = $urandom;
    @(negedge clk);
    if (ef) begin
      check({name, "_fvalid"}, 32'(flush_o_valid), 32'd1);
      check({name, "_fpc"}, flush_o_pc, epc);
      check({name, "_fcause"}, 32'(flush_o_cause), 32'(ec));
      check({name, "_ready_busy"}, 32'(cmt_i_ready), 32'd0);
      check({name, "_no_early_done"}, 32'(cmt_o_done), 32'd0);
      for (int k = 0; k < delay; k++) begin
        @(posedge clk); #1;
        if (k == delay - 1) flush_o_ready = 1'b1;
        @(negedge clk);
        check({name, "_hold_valid"}, 32'(flush_o_valid), 32'd1);
        check({name, "_hold_pc"}, flush_o_pc, epc);
        check({name, "_hold_cause"}, 32'(flush_o_cause), 32'(ec));
      end
      @(posedge clk); #1;
      flush_o_ready = 1'b0;
      if (ec == 2'd0) model_cnt++;
      @(negedge clk);
      check({name, "_flush_done"}, 32'(cmt_o_done), 32'd1);
      check({name, "_fvalid_drop"}, 32'(flush_o_valid), 32'd0);
      check({name, "_ready_back"}, 32'(cmt_i_ready), 32'd1);
    end else begin
      check({name, "_done"}, 32'(cmt_o_done), 32'd1);
      check({name, "_no_flush"}, 32'(flush_o_valid), 32'd0);
    end
    check_cnt(name);
  endtask

  vec_t vt[11];
  int   sat_exp[5] = '{1, 2, 3, 3, 3};

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary (got running, expected finished)");
    $fatal(1);
  end

  initial begin
    rec_t r;
    bit   ef;
    logic [31:0] epc;
    logic [1:0]  ec;

    vt[0]  = '{mk(32'h100, 32'h40, 0, 1, 1, 1, 0, 0, 0), 0, 32'h0, 2'd0, 0};
    vt[1]  = '{mk(32'h8000_0010, 32'hFFFF_FFF0, 0, 1, 0, 1, 0, 0, 0), 1, 32'h8000_0000, 2'd0, 3};
    vt[2]  = '{mk(32'h200, 32'h80, 1, 1, 1, 0, 0, 0, 0), 1, 32'h202, 2'd0, 1};
    vt[3]  = '{mk(32'h700, 32'h0, 0, 0, 0, 0, 1, 1, 0), 1, 32'h5000, 2'd3, 2};
    vt[4]  = '{mk(32'hFFFF_FFFC, 32'h0, 0, 0, 0, 0, 0, 0, 1), 1, 32'h0, 2'd1, 0};
    vt[5]  = '{mk(32'h300, 32'h10, 0, 0, 0, 0, 0, 0, 0), 0, 32'h0, 2'd0, 0};
    vt[6]  = '{mk(32'h400, 32'h0, 0, 0, 0, 0, 1, 0, 0), 1, 32'h6000, 2'd2, 1};
    vt[7]  = '{mk(32'h500, 32'h20, 0, 1, 0, 0, 0, 0, 0), 0, 32'h0, 2'd0, 0};
    vt[8]  = '{mk(32'h600, 32'h20, 0, 1, 0, 1, 1, 0, 1), 1, 32'h6000, 2'd2, 0};
    vt[9]  = '{mk(32'hFFFF_FFFE, 32'h4, 1, 1, 1, 0, 0, 0, 0), 1, 32'h0, 2'd0, 2};
    vt[10] = '{mk(32'h1000, 32'h234, 0, 1, 0, 1, 0, 0, 0), 1, 32'h1234, 2'd0, 0};

    rst_n = 1'b0;
    cmt_i_valid = 1'b0;
    flush_o_ready = 1'b0;
    drive(mk(32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmt_i_ready), 32'd1);
    check("rst_fvalid", 32'(flush_o_valid), 32'd0);
    check("rst_fpc", flush_o_pc, 32'd0);
    check("rst_fcause", 32'(flush_o_cause), 32'd0);
    check("rst_done", 32'(cmt_o_done), 32'd0);
    check_cnt("rst");
    rst_n = 1'b1;

    // Back-to-back correctly predicted branches, valid held four cycles.
    @(negedge clk);
    drive(mk(32'h100, 32'h40, 0, 1, 1, 1, 0, 0, 0));
    cmt_i_valid = 1'b1;
    check("b2b_ready0", 32'(cmt_i_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 3) cmt_i_valid = 1'b0;
      @(negedge clk);
      check("b2b_done", 32'(cmt_o_done), 32'd1);
      check("b2b_ready", 32'(cmt_i_ready), 32'd1);
      check("b2b_fvalid", 32'(flush_o_valid), 32'd0);
    end
    @(negedge clk);
    check("b2b_done_end", 32'(cmt_o_done), 32'd0);
    check_cnt("b2b");

    foreach (vt[i]) run_rec($sformatf("vec%0d", i), vt[i].r, vt[i].ef, vt[i].epc, vt[i].ec,
                            vt[i].delay, i[0]);

    // Reset asserted while a flush is pending.
    @(negedge clk);
    drive(mk(32'h900, 32'h100, 0, 1, 0, 1, 0, 0, 0));
    cmt_i_valid = 1'b1;
    flush_o_ready = 1'b0;
    @(posedge clk); #1;
    cmt_i_valid = 1'b0;
    @(negedge clk);
    check("rstmid_pending", 32'(flush_o_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_fvalid_drop", 32'(flush_o_valid), 32'd0);
    check("rstmid_done", 32'(cmt_o_done), 32'd0);
    model_cnt = 0;
    check_cnt("rstmid");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_ready", 32'(cmt_i_ready), 32'd1);
      check("rstmid_no_done", 32'(cmt_o_done), 32'd0);
      check("rstmid_idle", 32'(flush_o_valid), 32'd0);
    end
    check_cnt("rstmid_after");

    // Saturation of the 2-bit counter over five mispredict flushes.
    for (int i = 0; i < 5; i++) begin
      r = mk(32'h2000 + 32'(i * 16), 32'h8, 0, 1, 1, 0, 0, 0, 0);
      model(r, ef, epc, ec);
      run_rec("sat", r, ef, epc, ec, i % 2, 1'b0);
      check("sat_cnt2_seq", 32'(cnt2), 32'(sat_exp[i]));
    end

    for (int i = 0; i < 300; i++) begin
      r.pc = $urandom; r.imm = $urandom; r.rvc = 1'($urandom);
      r.bjp = 1'($urandom); r.prdt = 1'($urandom); r.rslv = 1'($urandom);
      r.mret = ($urandom_range(0, 7) == 0); r.dret = ($urandom_range(0, 9) == 0);
      r.fencei = ($urandom_range(0, 7) == 0);
      r.mepc = $urandom; r.dpc = $urandom;
      model(r, ef, epc, ec);
      run_rec("rnd", r, ef, epc, ec, $urandom_range(0, 3), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
